// File: rtl/instr_phase_sequencer_pkg.sv
// Shared constants for the instruction phase sequencer: phase state encodings,
// decoder group codes and the reset NOP encoding.
package instr_phase_sequencer_pkg;

    typedef enum logic [1:0] {
        SEQ_F = 2'b00,
        SEQ_D = 2'b01,
        SEQ_E = 2'b10,
        SEQ_C = 2'b11
    } seq_state_t;

    localparam logic [1:0] GRP_SYS = 2'b00;
    localparam logic [1:0] GRP_LDS = 2'b01;
    localparam logic [1:0] GRP_JMP = 2'b10;
    localparam logic [1:0] GRP_ALU = 2'b11;

    // Group 0, SYSF 0: a NOP the system decoder executes harmlessly.
    localparam logic [15:0] NOP_INSTR = 16'h0000;

    function automatic logic [1:0] instr_group(input logic [15:0] instr);
        return instr[15:14];
    endfunction

endpackage

// File: rtl/instr_phase_sequencer_seq_wait_timer.sv
// Fetch wait-state counter: counts consecutive not-ready fetch cycles and flags
// a timeout on the MAX_WAIT-th one.
module seq_wait_timer #(
    parameter int unsigned MAX_WAIT = 15
) (
    input  logic CLK,
    input  logic RESETN,
    input  logic fetch_active,
    input  logic mem_ready,
    output logic timeout
);

    localparam logic [7:0] LAST_WAIT = 8'(MAX_WAIT - 1);

    logic [7:0] count;

    assign timeout = fetch_active & ~mem_ready & (count == LAST_WAIT);

    // NOTE: non-blocking assignments for all flops so every register samples
    // pre-edge values regardless of block evaluation order.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            count <= 8'd0;
        end else if (!fetch_active || mem_ready || timeout) begin
            count <= 8'd0;
        end else begin
            count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/instr_phase_sequencer.sv
// Four-phase FETCH/DECODE/EXECUTE/COMMIT sequencer with instruction register.
// Define SEQ_WAIT_STATE_EN to honour MEM_READY with a MAX_WAIT fetch timeout.
module instr_phase_sequencer
    import instr_phase_sequencer_pkg::*;
#(
    parameter logic [15:0] RESET_INSTR = NOP_INSTR,
    parameter int unsigned MAX_WAIT    = 15
) (
    input  logic        CLK,
    input  logic        RESETN,
    input  logic [15:0] MEM_DATA,
    input  logic        MEM_READY,
    input  logic        HOLD,
    output logic        MEM_RD,
    output logic [15:0] INSTRUCTION,
    output logic [1:0]  GROUPX,
    output logic        FETCH,
    output logic        DECODE,
    output logic        EXECUTE,
    output logic        COMMIT,
    output logic        PC_INC,
    output logic        BUS_ERR
);

    seq_state_t  state;
    logic [15:0] instr_q;
    logic        pc_inc_q;
    logic        fetch_done;
    logic        fetch_timeout;

`ifdef SEQ_WAIT_STATE_EN
    logic in_fetch;
    logic bus_err_q;

    assign in_fetch   = (state == SEQ_F);
    assign fetch_done = MEM_READY;

    seq_wait_timer #(.MAX_WAIT(MAX_WAIT)) u_wait_timer (
        .CLK          (CLK),
        .RESETN       (RESETN),
        .fetch_active (in_fetch),
        .mem_ready    (MEM_READY),
        .timeout      (fetch_timeout)
    );

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            bus_err_q <= 1'b0;
        end else if (fetch_timeout) begin
            bus_err_q <= 1'b1;
        end
    end

    assign BUS_ERR = bus_err_q;
`else
    logic [8:0] unused_cfg;

    assign unused_cfg    = {MEM_READY, 8'(MAX_WAIT)};
    assign fetch_done    = 1'b1;
    assign fetch_timeout = 1'b0;
    assign BUS_ERR       = 1'b0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state    <= SEQ_F;
            instr_q  <= RESET_INSTR;
            pc_inc_q <= 1'b0;
        end else begin
            pc_inc_q <= 1'b0;
            case (state)
                SEQ_F: begin
                    if (fetch_done) begin
                        instr_q <= MEM_DATA;
                        state   <= SEQ_D;
                    end else if (fetch_timeout) begin
                        instr_q <= RESET_INSTR;
                        state   <= SEQ_D;
                    end
                end
                SEQ_D: state <= SEQ_E;
                SEQ_E: state <= SEQ_C;
                SEQ_C: begin
                    // Commit actions are idempotent, so holding COMMIT during a stall is safe.
                    if (!HOLD) begin
                        pc_inc_q <= 1'b1;
                        state    <= SEQ_F;
                    end
                end
                default: state <= SEQ_F;
            endcase
        end
    end

    // Gated by RESETN so the read strobe drops the instant reset asserts.
    assign MEM_RD      = (state == SEQ_F) & RESETN;
    assign INSTRUCTION = instr_q;
    assign GROUPX      = instr_group(instr_q);
    assign FETCH       = (state == SEQ_F);
    assign DECODE      = (state == SEQ_D);
    assign EXECUTE     = (state == SEQ_E);
    assign COMMIT      = (state == SEQ_C);
    assign PC_INC      = pc_inc_q;

endmodule

// File: tb/tb_instr_phase_sequencer.sv
// Self-checking bench for instr_phase_sequencer: directed phase/HOLD/reset steps
// and random traffic compared against a phase-counting reference model.
module tb_instr_phase_sequencer;

    localparam logic [15:0] RESET_INSTR = 16'h0000;
    localparam int          MAX_WAIT    = 15;

    logic        CLK = 1'b0;
    logic        RESETN = 1'b0;
    logic [15:0] MEM_DATA = 16'h0000;
    logic        MEM_READY = 1'b1;
    logic        HOLD = 1'b0;
    logic        MEM_RD;
    logic [15:0] INSTRUCTION;
    logic [1:0]  GROUPX;
    logic        FETCH, DECODE, EXECUTE, COMMIT;
    logic        PC_INC;
    logic        BUS_ERR;

    int errors = 0;
    int checks = 0;

    // Reference model: phase index 0..3 = F,D,E,C plus architectural outputs.
    int          m_phase;
    logic [15:0] m_instr;
    logic        m_pcinc;
    logic        m_buserr;
    int          m_wait;

    instr_phase_sequencer #(
        .RESET_INSTR (RESET_INSTR),
        .MAX_WAIT    (MAX_WAIT)
    ) dut (
        .CLK         (CLK),
        .RESETN      (RESETN),
        .MEM_DATA    (MEM_DATA),
        .MEM_READY   (MEM_READY),
        .HOLD        (HOLD),
        .MEM_RD      (MEM_RD),
        .INSTRUCTION (INSTRUCTION),
        .GROUPX      (GROUPX),
        .FETCH       (FETCH),
        .DECODE      (DECODE),
        .EXECUTE     (EXECUTE),
        .COMMIT      (COMMIT),
        .PC_INC      (PC_INC),
        .BUS_ERR     (BUS_ERR)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase  = 0;
        m_instr  = RESET_INSTR;
        m_pcinc  = 1'b0;
        m_buserr = 1'b0;
        m_wait   = 0;
    endtask

    task automatic model_step();
        m_pcinc = 1'b0;
        case (m_phase)
            0: begin
`ifdef SEQ_WAIT_STATE_EN
                if (MEM_READY) begin
                    m_instr = MEM_DATA;
                    m_phase = 1;
                    m_wait  = 0;
                end else if (m_wait + 1 == MAX_WAIT) begin
                    m_instr  = RESET_INSTR;
                    m_buserr = 1'b1;
                    m_phase  = 1;
                    m_wait   = 0;
                end else begin
                    m_wait++;
                end
`else
                m_instr = MEM_DATA;
                m_phase = 1;
`endif
            end
            3: begin
                if (!HOLD) begin
                    m_phase = 0;
                    m_pcinc = 1'b1;
                end
            end
            default: m_phase++;
        endcase
    endtask

    task automatic check_outputs(input string tag);
        logic [3:0] phases;
        phases = {FETCH, DECODE, EXECUTE, COMMIT};
        check({tag, ".phase"},  16'(phases), 16'(4'b1000 >> m_phase));
        check({tag, ".onehot"}, 16'($onehot(phases)), 16'd1);
        check({tag, ".instr"},  INSTRUCTION, m_instr);
        check({tag, ".groupx"}, 16'(GROUPX), 16'(m_instr[15:14]));
        check({tag, ".pc_inc"}, 16'(PC_INC), 16'(m_pcinc));
        check({tag, ".bus_err"}, 16'(BUS_ERR), 16'(m_buserr));
        check({tag, ".mem_rd"}, 16'(MEM_RD), 16'((m_phase == 0) && RESETN));
    endtask

    task automatic tick(input string tag);
        @(posedge CLK);
        if (RESETN) model_step();
        @(negedge CLK);
        check_outputs(tag);
    endtask

    task automatic advance_to(input int ph, input string tag);
        int n;
        n = 0;
        while (m_phase != ph && n < 8) begin
            tick(tag);
            n++;
        end
        check({tag, ".reach"}, 16'({FETCH, DECODE, EXECUTE, COMMIT}), 16'(4'b1000 >> ph));
    endtask

    initial begin
        int pulses;
        int cnt;

        // Reset state
        model_reset();
        @(negedge CLK);
        check_outputs("reset");
        @(negedge CLK);
        check_outputs("reset2");
        RESETN = 1'b1;

        // Back-to-back instructions, no stall
        MEM_DATA = 16'hC512;
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            tick("run");
            if (PC_INC) pulses++;
        end
        check("run.pc_pulses", 16'(pulses), 16'd3);
        check("run.groupx_alu", 16'(GROUPX), 16'(2'b11));

        // HOLD stall in COMMIT
        advance_to(3, "hold_pre");
        HOLD = 1'b1;
        MEM_DATA = 16'h1234;
        cnt = COMMIT ? 1 : 0;
        for (int i = 0; i < 3; i++) begin
            tick("hold");
            if (COMMIT) cnt++;
        end
        check("hold.commit_cycles", 16'(cnt), 16'd4);
        check("hold.instr_kept", INSTRUCTION, 16'hC512);
        HOLD = 1'b0;
        tick("hold_rel");
        check("hold_rel.pc_inc", 16'(PC_INC), 16'd1);
        tick("hold_fetch");
        check("hold_fetch.instr", INSTRUCTION, 16'h1234);

        // Asynchronous reset in the middle of EXECUTE
        advance_to(2, "arst_pre");
        #2 RESETN = 1'b0;
        model_reset();
        #1 check_outputs("arst");
        @(negedge CLK);
        check_outputs("arst_hold");
        MEM_DATA = 16'h8001;
        RESETN = 1'b1;
        pulses = 0;
        for (int i = 0; i < 8; i++) begin
            tick("arst_rel");
            if (PC_INC) pulses++;
        end
        check("arst_rel.pc_pulses", 16'(pulses), 16'd2);

`ifdef SEQ_WAIT_STATE_EN
        // Three wait states, then data
        advance_to(3, "wait_pre");
        MEM_READY = 1'b0;
        tick("wait");
        cnt = 0;
        while (FETCH && cnt < 40) begin
            cnt++;
            if (cnt == 4) begin
                MEM_READY = 1'b1;
                MEM_DATA  = 16'h4A37;
            end
            tick("wait");
        end
        check("wait.fetch_cycles", 16'(cnt), 16'd4);
        check("wait.instr", INSTRUCTION, 16'h4A37);
        check("wait.bus_err", 16'(BUS_ERR), 16'd0);

        // MEM_READY stuck low: timeout
        advance_to(3, "tmo_pre");
        MEM_READY = 1'b0;
        tick("tmo");
        cnt = 0;
        while (FETCH && cnt < 40) begin
            cnt++;
            tick("tmo");
        end
        check("tmo.fetch_cycles", 16'(cnt), 16'(MAX_WAIT));
        check("tmo.bus_err", 16'(BUS_ERR), 16'd1);
        check("tmo.instr_nop", INSTRUCTION, RESET_INSTR);
        check("tmo.decode", 16'(DECODE), 16'd1);
        MEM_READY = 1'b1;
        for (int i = 0; i < 8; i++) tick("tmo_sticky");
        check("tmo_sticky.bus_err", 16'(BUS_ERR), 16'd1);
        #2 RESETN = 1'b0;
        model_reset();
        #1 check_outputs("tmo_rst");
        @(negedge CLK);
        RESETN = 1'b1;
`else
        // MEM_READY is ignored without wait states
        advance_to(3, "nowait_pre");
        MEM_READY = 1'b0;
        MEM_DATA  = 16'h4A37;
        tick("nowait");
        tick("nowait");
        check("nowait.instr", INSTRUCTION, 16'h4A37);
        check("nowait.decode", 16'(DECODE), 16'd1);
        MEM_READY = 1'b1;
`endif

        // Random traffic
        for (int i = 0; i < 10000; i++) begin
            HOLD      = 1'($urandom_range(0, 1));
            MEM_DATA  = 16'($urandom);
            MEM_READY = ($urandom_range(0, 3) != 0);
            tick("rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
